// File: rtl/gdp_feeder_pkg.sv
// Shared sizing helpers and types for the GDP feeder and its observation store.
package gdp_feeder_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } feeder_state_t;

  // Address width that stays at least one bit wide for single-entry spaces.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gdp_feeder_if.sv
// Operand stream from the feeder into gdp, and gdp's in-order ln_p result back.
interface gdp_feeder_if #(
  parameter int DATA_W = gdp_feeder_pkg::DATA_W
);

  logic              first_calc;
  logic              last_calc;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] omega;
  logic [DATA_W-1:0] mean;
  logic              gdp_data_ready;
  logic [DATA_W-1:0] gdp_ln_p;

  modport master (
    output first_calc, last_calc, x, k, omega, mean,
    input  gdp_data_ready, gdp_ln_p
  );

  modport slave (
    input  first_calc, last_calc, x, k, omega, mean,
    output gdp_data_ready, gdp_ln_p
  );

endinterface

// File: rtl/gdp_feeder_obs_regfile.sv
// Observation vector store: one synchronous write port, one asynchronous read port.
module gdp_feeder_obs_regfile
  import gdp_feeder_pkg::*;
#(
  parameter int N_COMP = 39,
  parameter int DATA_W = gdp_feeder_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(N_COMP)-1:0] waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [addr_w(N_COMP)-1:0] raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [N_COMP];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < N_COMP)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gdp_feeder.sv
// GDP feeder: streams one observation vector against every HMM state's parameters
// into gdp, then tags each in-order ln_p result with its state index.
module gdp_feeder
  import gdp_feeder_pkg::*;
#(
  parameter int N_COMP   = 39,
  parameter int N_STATES = 8,
  parameter int DATA_W   = gdp_feeder_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               obs_wr_en,
  input  logic [addr_w(N_COMP)-1:0]          obs_wr_addr,
  input  logic [DATA_W-1:0]                  obs_wr_data,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [addr_w(N_STATES*N_COMP)-1:0] param_addr,
  output logic [addr_w(N_STATES)-1:0]        k_addr,
  output logic                               param_rd_en,
  input  logic [2*DATA_W-1:0]                param_rdata,
  input  logic [DATA_W-1:0]                  k_rdata,
  gdp_feeder_if.master                       gdp,
  output logic                               result_valid,
  output logic [addr_w(N_STATES)-1:0]        result_state,
  output logic [DATA_W-1:0]                  result_ln_p
);

  localparam int CW = addr_w(N_COMP);
  localparam int SW = addr_w(N_STATES);
  localparam int PW = addr_w(N_STATES*N_COMP);
  localparam int RW = $clog2(N_STATES + 1);

  feeder_state_t     fsm_q, fsm_d;
  logic              issue;
  logic [CW-1:0]     comp_q;
  logic [SW-1:0]     state_q;
  logic [PW-1:0]     addr_q;
  logic [RW-1:0]     res_cnt_q;
  logic              comp_last, state_last, last_issue, all_results, accept;
  logic              obs_we;
  logic [DATA_W-1:0] obs_rdata;

  logic              vld_p0, first_p0, last_p0;
  logic [DATA_W-1:0] x_p0;
  logic              first_p1, last_p1;
  logic [DATA_W-1:0] x_p1, k_p1, mean_p1, omega_p1;

  assign comp_last   = (comp_q == CW'(N_COMP - 1));
  assign state_last  = (state_q == SW'(N_STATES - 1));
  assign last_issue  = issue && comp_last && state_last;
  assign all_results = (res_cnt_q == RW'(N_STATES));
  // Results beyond the run's quota, or arriving while idle, are stale and dropped.
  assign accept      = gdp.gdp_data_ready && (fsm_q != IDLE) && !all_results;
  assign obs_we      = obs_wr_en && (fsm_q == IDLE);

  gdp_feeder_obs_regfile #(
    .N_COMP (N_COMP),
    .DATA_W (DATA_W)
  ) u_obs (
    .clk   (clk),
    .we    (obs_we),
    .waddr (obs_wr_addr),
    .wdata (obs_wr_data),
    .raddr (comp_q),
    .rdata (obs_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    issue = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) fsm_d = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_issue) fsm_d = DRAIN;
      end
      DRAIN: begin
        if (all_results) fsm_d = DONE;
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign busy        = (fsm_q != IDLE);
  assign done        = (fsm_q == DONE);
  assign param_rd_en = issue;
  assign param_addr  = issue ? addr_q : '0;
  assign k_addr      = issue ? state_q : '0;

  // Component index runs fastest; the state index parks on the last state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_q  <= '0;
      state_q <= '0;
      addr_q  <= '0;
    end else if (fsm_q == IDLE) begin
      comp_q  <= '0;
      state_q <= '0;
      addr_q  <= '0;
    end else if (issue) begin
      if (!last_issue) addr_q <= addr_q + 1'b1;
      if (comp_last) begin
        comp_q <= '0;
        if (!state_last) state_q <= state_q + 1'b1;
      end else begin
        comp_q <= comp_q + 1'b1;
      end
    end
  end

  // Stage p0: address on the RAM bus; capture framing and the matching obs word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0   <= issue;
      first_p0 <= issue && (comp_q == '0);
      last_p0  <= issue && comp_last;
    end
  end

  always_ff @(posedge clk) begin
    x_p0 <= obs_rdata;
  end

  // Stage p1: RAM data has returned; register the aligned gdp operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      x_p1     <= '0;
      k_p1     <= '0;
      mean_p1  <= '0;
      omega_p1 <= '0;
    end else begin
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      x_p1     <= vld_p0 ? x_p0 : '0;
      mean_p1  <= vld_p0 ? param_rdata[2*DATA_W-1:DATA_W] : '0;
      omega_p1 <= vld_p0 ? param_rdata[DATA_W-1:0] : '0;
      if (!vld_p0) begin
        k_p1 <= '0;
      end else if (first_p0) begin
        k_p1 <= k_rdata;
      end
    end
  end

  assign gdp.first_calc = first_p1;
  assign gdp.last_calc  = last_p1;
  assign gdp.x          = x_p1;
  assign gdp.k          = k_p1;
  assign gdp.mean       = mean_p1;
  assign gdp.omega      = omega_p1;

  // gdp returns results in issue order, so the arrival count is the state index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_cnt_q    <= '0;
      result_valid <= 1'b0;
      result_state <= '0;
      result_ln_p  <= '0;
    end else begin
      if (fsm_q == IDLE) begin
        res_cnt_q <= '0;
      end else if (accept) begin
        res_cnt_q <= res_cnt_q + 1'b1;
      end
      result_valid <= accept;
      result_state <= accept ? res_cnt_q[SW-1:0] : '0;
      result_ln_p  <= accept ? gdp.gdp_ln_p : '0;
    end
  end

endmodule
